ram_bus_arbiter: RTL and testbench
==================================

// Module: ram_bus_arbiter
// PURPOSE
//  Parametrised owner-select for the shared emulation SRAM, replacing the fixed load/CPU/diag muxing at top level.
//  Sequences ownership as LOAD (flash loader), RUN (CPU), HALT_WAIT and HALTED (diagnostics).
//  Halts the CPU only on a bus-cycle boundary, so a CPU access is never cut mid-cycle.
//  Generates the video-RAM write strobe from a per-configuration table of address windows, programmable at runtime.
// PARAMETERS
//  ADDR_W       16     RAM/CPU address width
//  DATA_W       8      data width
//  CFG_W        4      configuration index width; table depth is 2**CFG_W
//  VRAM_AW      11     video-RAM address width
//  MIRROR_ADDR  59468  single CPU address also captured into video RAM
//  MIRROR_OFS   1000   video-RAM offset used for MIRROR_ADDR
//  SYNC_STAGES  2      phi2 synchroniser depth (>=2)
// PORTS
//  clk          in   1        system clock (HFOSC)
//  rst          in   1        synchronous reset, active high
//  load_done    in   1        flash loader finished filling RAM
//  halt_req     in   1        diagnostics requests CPU halt (level)
//  phi2         in   1        CPU phase-2 clock, asynchronous to clk
//  cpu_addr     in   ADDR_W   CPU address bus
//  cpu_din      in   DATA_W   CPU write data
//  cpu_cs       in   1        CPU RAM select, from ramenable
//  cpu_we       in   1        CPU RAM write enable
//  flash_addr   in   ADDR_W   flash loader address; flash_din/cs/we: DATA_W/1/1 likewise
//  diag_addr    in   ADDR_W   diagnostics address; diag_din/cs/we: DATA_W/1/1 likewise
//  ram_addr     out  ADDR_W   muxed SRAM address; ram_din/cs/we: DATA_W/1/1 likewise
//  ram_dout     in   DATA_W   SRAM read data
//  cpu_dout     out  DATA_W   data to CPU pads (0 unless RUN)
//  cpu_dout_en  out  1        pad output enable
//  rdy          out  1        CPU RDY
//  halted       out  1        diagnostics owns the bus
//  cfg_sel      in   CFG_W    active configuration
//  win_wr       in   1        write window table entry
//  win_idx      in   CFG_W    entry to write
//  win_start    in   ADDR_W   window start (inclusive)
//  win_end      in   ADDR_W   window end (exclusive)
//  vram_we      out  1        video-RAM write strobe
//  vram_waddr   out  VRAM_AW  video-RAM write address
//  vram_wdata   out  DATA_W   video-RAM write data
//  vram_size    out  VRAM_AW  end-start of the cfg_sel window, truncated
// BEHAVIOUR
//  State register only: state/halted/rdy registered; mux outputs combinational from state.
//  Reset: state=LOAD; rdy=0; halted=0; cpu_dout_en=0; vram_we=0; all table entries start=end=0; sync chain=0.
//  LOAD: flash_* drives ram_*; cpu_dout_en=0. load_done=1 -> RUN on the next clk.
//  RUN: cpu_* drives ram_*; rdy=1; cpu_dout=ram_dout; cpu_dout_en=cpu_cs&~cpu_we.
//   - halt_req=1 -> HALT_WAIT, rdy=0 registered on the same edge.
//   - load_done falling is ignored; only rst returns the block to LOAD.
//  HALT_WAIT: CPU still owns ram_*; rdy=0.
//   - Synchronised phi2 1->0 -> HALTED.
//   - halt_req=0 first -> RUN.
//   - If halt_req=0 and the phi2 fall arrive in the same cycle, halt_req wins (-> RUN).
//  HALTED: diag_* drives ram_*; halted=1; rdy=0; cpu_dout=0; cpu_dout_en=0.
//   - halt_req=0 -> RUN next clk; rdy=1 and halted=0 on the same edge.
//  Window hit: start<=ram_addr<end for table[cfg_sel], unsigned compare.
//   - start>=end gives an empty window.
//   - ram_addr==MIRROR_ADDR always hits and takes priority, using offset MIRROR_OFS.
//   - Any other hit uses offset (ram_addr-start)[VRAM_AW-1:0].
//  vram_*: registered one cycle after a hit with ram_cs&ram_we in any state, including LOAD and HALTED.
//   - vram_wdata is ram_din of that cycle.
//  win_wr updates the entry on the next edge.
//   - A write to the active entry affects hit decoding from the following cycle.
//  vram_size is combinational from table[cfg_sel].
//  rst mid-operation: immediate return to LOAD; a pending vram_we is dropped.
// TESTING
//  - rst, load_done=0, flash write 0x12 @0x0100 -> ram_we=1, ram_addr=0x0100, rdy=0; load_done=1 -> rdy=1 after 1 clk.
//  - RUN, halt_req=1 with phi2 high -> rdy=0 next clk, halted=0; phi2 fall -> halted=1 within SYNC_STAGES+1 clks.
//  - HALTED, diag read @0x8000 -> ram_addr=0x8000, cpu_dout=0, cpu_dout_en=0; halt_req=0 -> rdy=1 next clk.
//  - Window cfg 3 = 0x8000..0x83E8, cfg_sel=3, CPU write 0x41 @0x8005 -> 1 clk later vram_we=1, waddr=5, wdata=0x41.
//  - CPU write @0x83E8 -> vram_we=0; write @59468 -> vram_waddr=1000; window start=end -> only 59468 hits.
//  - halt_req pulse dropped in HALT_WAIT before phi2 falls -> back to RUN, halted never asserts.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// Shared emulation SRAM owner-select: LOAD/RUN/HALT_WAIT/HALTED sequencing,
// bus mux, CPU RDY/halt handshake and windowed video-RAM write capture.
//
// Ports:
//  clk, rst (sync, active high)
//  load_done, halt_req, phi2 (async to clk)   : sequencing controls
//  cpu_*, flash_*, diag_*                     : the three bus masters
//  ram_addr/din/cs/we out, ram_dout in        : muxed SRAM port
//  cpu_dout, cpu_dout_en, rdy, halted         : CPU pad data and status
//  cfg_sel, win_wr, win_idx, win_start/end    : window table select/program
//  vram_we, vram_waddr, vram_wdata, vram_size : video-RAM write strobe/info
module ram_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int CFG_W       = 4,
  parameter int VRAM_AW     = 11,
  parameter int MIRROR_ADDR = 59468,
  parameter int MIRROR_OFS  = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_done,
  input  logic              halt_req,
  input  logic              phi2,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [DATA_W-1:0] flash_din,
  input  logic              flash_cs,
  input  logic              flash_we,
  input  logic [ADDR_W-1:0] diag_addr,
  input  logic [DATA_W-1:0] diag_din,
  input  logic              diag_cs,
  input  logic              diag_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_cs,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_dout_en,
  output logic              rdy,
  output logic              halted,
  input  logic [CFG_W-1:0]  cfg_sel,
  input  logic              win_wr,
  input  logic [CFG_W-1:0]  win_idx,
  input  logic [ADDR_W-1:0] win_start,
  input  logic [ADDR_W-1:0] win_end,
  output logic              vram_we,
  output logic [VRAM_AW-1:0] vram_waddr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic [VRAM_AW-1:0] vram_size
);

  localparam int DEPTH = 1 << CFG_W;
  localparam logic [ADDR_W-1:0] MIR_A = ADDR_W'(MIRROR_ADDR);
  localparam logic [VRAM_AW-1:0] MIR_O = VRAM_AW'(MIRROR_OFS);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    HALT_WAIT,
    HALTED
  } state_t;

  state_t state_q, state_d;

  // Chain has one extra stage so the last two bits give the edge.
  logic [SYNC_STAGES:0] sync_q;
  logic                 phi2_fall;

  logic [ADDR_W-1:0] tbl_start [DEPTH];
  logic [ADDR_W-1:0] tbl_end   [DEPTH];

  logic [ADDR_W-1:0] cur_start, cur_end;
  logic [ADDR_W-1:0] rel_addr, win_len;
  logic              win_hit, mir_hit, hit;
  logic [VRAM_AW-1:0] hit_ofs;

  assign phi2_fall = sync_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:      if (load_done) state_d = RUN;
      RUN:       if (halt_req) state_d = HALT_WAIT;
      // A dropped request beats a simultaneous phi2 fall.
      HALT_WAIT: if (!halt_req) state_d = RUN;
                 else if (phi2_fall) state_d = HALTED;
      HALTED:    if (!halt_req) state_d = RUN;
      default:   state_d = LOAD;
    endcase
  end

  always_comb begin
    ram_addr    = cpu_addr;
    ram_din     = cpu_din;
    ram_cs      = cpu_cs;
    ram_we      = cpu_we;
    cpu_dout    = '0;
    cpu_dout_en = 1'b0;
    unique case (state_q)
      LOAD: begin
        ram_addr = flash_addr;
        ram_din  = flash_din;
        ram_cs   = flash_cs;
        ram_we   = flash_we;
      end
      RUN: begin
        cpu_dout    = ram_dout;
        cpu_dout_en = cpu_cs & ~cpu_we;
      end
      HALTED: begin
        ram_addr = diag_addr;
        ram_din  = diag_din;
        ram_cs   = diag_cs;
        ram_we   = diag_we;
      end
      default: ;
    endcase
  end

  assign cur_start = tbl_start[cfg_sel];
  assign cur_end   = tbl_end[cfg_sel];
  assign rel_addr  = ram_addr - cur_start;
  assign win_len   = cur_end - cur_start;
  assign vram_size = win_len[VRAM_AW-1:0];

  // start>=end can never satisfy both compares, so it is empty.
  assign win_hit = (ram_addr >= cur_start) && (ram_addr < cur_end);
  assign mir_hit = (ram_addr == MIR_A);
  assign hit     = win_hit | mir_hit;
  assign hit_ofs = mir_hit ? MIR_O : rel_addr[VRAM_AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      rdy        <= 1'b0;
      halted     <= 1'b0;
      sync_q     <= '0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_start[i] <= '0;
        tbl_end[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      rdy        <= (state_d == RUN);
      halted     <= (state_d == HALTED);
      sync_q     <= {sync_q[SYNC_STAGES-1:0], phi2};
      vram_we    <= hit & ram_cs & ram_we;
      vram_waddr <= hit_ofs;
      vram_wdata <= ram_din;
      if (win_wr) begin
        tbl_start[win_idx] <= win_start;
        tbl_end[win_idx]   <= win_end;
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed sequencing scenarios
// plus randomized window/CPU traffic against a table-level reference model.
module tb_ram_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int VW = 11;
  localparam int SS = 2;
  localparam int MIRA = 59468;
  localparam int MIRO = 1000;

  logic clk = 0;
  logic rst, load_done, halt_req, phi2;
  logic [AW-1:0] cpu_addr, flash_addr, diag_addr, ram_addr;
  logic [DW-1:0] cpu_din, flash_din, diag_din, ram_din, ram_dout, cpu_dout;
  logic cpu_cs, cpu_we, flash_cs, flash_we, diag_cs, diag_we;
  logic ram_cs, ram_we, cpu_dout_en, rdy, halted;
  logic [CW-1:0] cfg_sel, win_idx;
  logic win_wr;
  logic [AW-1:0] win_start, win_end;
  logic vram_we;
  logic [VW-1:0] vram_waddr, vram_size;
  logic [DW-1:0] vram_wdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  int m_start [16];
  int m_end   [16];

  always #5 clk = ~clk;

  ram_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CFG_W(CW), .VRAM_AW(VW),
    .MIRROR_ADDR(MIRA), .MIRROR_OFS(MIRO), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .load_done(load_done), .halt_req(halt_req),
    .phi2(phi2), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .flash_addr(flash_addr),
    .flash_din(flash_din), .flash_cs(flash_cs), .flash_we(flash_we),
    .diag_addr(diag_addr), .diag_din(diag_din), .diag_cs(diag_cs),
    .diag_we(diag_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_dout(ram_dout),
    .cpu_dout(cpu_dout), .cpu_dout_en(cpu_dout_en), .rdy(rdy),
    .halted(halted), .cfg_sel(cfg_sel), .win_wr(win_wr),
    .win_idx(win_idx), .win_start(win_start), .win_end(win_end),
    .vram_we(vram_we), .vram_waddr(vram_waddr),
    .vram_wdata(vram_wdata), .vram_size(vram_size)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected capture from the window rules: mirror first, then table range.
  function automatic int exp_ofs(input int a, input int cfg, output bit h);
    h = 0;
    exp_ofs = 0;
    if (a == MIRA) begin
      h = 1;
      exp_ofs = MIRO;
    end else if (a >= m_start[cfg] && a < m_end[cfg]) begin
      h = 1;
      exp_ofs = (a - m_start[cfg]) % (1 << VW);
    end
  endfunction

  task automatic win_write(input int idx, input int s, input int e);
    win_wr = 1; win_idx = CW'(idx);
    win_start = AW'(s); win_end = AW'(e);
    tick();
    m_start[idx] = s; m_end[idx] = e;
    win_wr = 0;
  endtask

  task automatic cpu_write(input int a, input int d);
    cpu_addr = AW'(a); cpu_din = DW'(d); cpu_cs = 1; cpu_we = 1;
  endtask

  task automatic test_reset();
    rst = 1; load_done = 0; halt_req = 0; phi2 = 0;
    cpu_addr = 0; cpu_din = 0; cpu_cs = 0; cpu_we = 0;
    flash_addr = 0; flash_din = 0; flash_cs = 0; flash_we = 0;
    diag_addr = 0; diag_din = 0; diag_cs = 0; diag_we = 0;
    ram_dout = 0; cfg_sel = 0; win_wr = 0; win_idx = 0;
    win_start = 0; win_end = 0;
    for (int i = 0; i < 16; i++) begin m_start[i] = 0; m_end[i] = 0; end
    tick(); tick();
    rst = 0;
    #1;
    total_cnt++;
    if ({rdy, halted, cpu_dout_en, vram_we} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000",
               {rdy, halted, cpu_dout_en, vram_we});
    else pass_cnt++;
    total_cnt++;
    if (vram_size !== 0)
      $display("FAIL reset_size got %0d want 0", vram_size);
    else pass_cnt++;
  endtask

  task automatic test_load();
    flash_addr = 16'h0100; flash_din = 8'h12; flash_cs = 1; flash_we = 1;
    cpu_addr = 16'h2222; cpu_cs = 1; cpu_we = 0;
    #1;
    total_cnt++;
    if ({ram_we, ram_cs, ram_addr, ram_din, rdy} !== {2'b11, 16'h0100, 8'h12, 1'b0})
      $display("FAIL load_mux got we%b cs%b a%h d%h rdy%b want we1 cs1 a0100 d12 rdy0",
               ram_we, ram_cs, ram_addr, ram_din, rdy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rdy !== 0 || vram_we !== 0)
      $display("FAIL load_hold got rdy%b vwe%b want 0 0", rdy, vram_we);
    else pass_cnt++;
    flash_cs = 0; flash_we = 0;
    load_done = 1;
    tick();
    total_cnt++;
    if (rdy !== 1 || ram_addr !== 16'h2222)
      $display("FAIL load_to_run got rdy%b a%h want 1 2222", rdy, ram_addr);
    else pass_cnt++;
    load_done = 0;
    tick();
    total_cnt++;
    if (rdy !== 1)
      $display("FAIL load_done_fall got rdy%b want 1", rdy);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    int n;
    phi2 = 1;
    repeat (4) tick();
    halt_req = 1;
    cpu_addr = 16'h3333; cpu_cs = 0;
    tick();
    total_cnt++;
    if (rdy !== 0 || halted !== 0 || ram_addr !== 16'h3333)
      $display("FAIL halt_wait got rdy%b h%b a%h want 0 0 3333",
               rdy, halted, ram_addr);
    else pass_cnt++;
    phi2 = 0;
    n = 0;
    while (halted !== 1 && n < SS + 1) begin
      tick();
      n++;
    end
    total_cnt++;
    if (halted !== 1)
      $display("FAIL halt_phi2 got halted%b after %0d clks want 1 within %0d",
               halted, n, SS + 1);
    else pass_cnt++;
  endtask

  task automatic test_halted_diag();
    diag_addr = 16'h8000; diag_cs = 1; diag_we = 0;
    cpu_cs = 1; cpu_we = 0; ram_dout = 8'h5A;
    #1;
    total_cnt++;
    if (ram_addr !== 16'h8000 || cpu_dout !== 0 || cpu_dout_en !== 0 || rdy !== 0)
      $display("FAIL diag_read got a%h do%h en%b rdy%b want 8000 00 0 0",
               ram_addr, cpu_dout, cpu_dout_en, rdy);
    else pass_cnt++;
    halt_req = 0;
    tick();
    total_cnt++;
    if (rdy !== 1 || halted !== 0)
      $display("FAIL unhalt got rdy%b h%b want 1 0", rdy, halted);
    else pass_cnt++;
    total_cnt++;
    if (cpu_dout !== 8'h5A || cpu_dout_en !== 1)
      $display("FAIL run_read got do%h en%b want 5a 1", cpu_dout, cpu_dout_en);
    else pass_cnt++;
    diag_cs = 0; cpu_cs = 0;
  endtask

  task automatic test_window();
    win_write(3, 16'h8000, 16'h83E8);
    cfg_sel = 3;
    #1;
    total_cnt++;
    if (vram_size !== 11'd1000)
      $display("FAIL win_size got %0d want 1000", vram_size);
    else pass_cnt++;
    cpu_write(16'h8005, 8'h41);
    tick();
    total_cnt++;
    if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 11'd5, 8'h41})
      $display("FAIL win_hit got we%b a%0d d%h want 1 5 41",
               vram_we, vram_waddr, vram_wdata);
    else pass_cnt++;
    cpu_write(16'h83E8, 8'h42);
    tick();
    total_cnt++;
    if (vram_we !== 0)
      $display("FAIL win_end_excl got we%b want 0", vram_we);
    else pass_cnt++;
    cpu_write(MIRA, 8'h77);
    tick();
    total_cnt++;
    if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 11'd1000, 8'h77})
      $display("FAIL mirror got we%b a%0d d%h want 1 1000 77",
               vram_we, vram_waddr, vram_wdata);
    else pass_cnt++;
    cpu_cs = 0; cpu_we = 0;
  endtask

  task automatic test_mirror_empty();
    win_write(3, 16'h8000, 16'h8000);
    cpu_write(16'h8005, 8'h11);
    tick();
    total_cnt++;
    if (vram_we !== 0 || vram_size !== 0)
      $display("FAIL empty_win got we%b size%0d want 0 0", vram_we, vram_size);
    else pass_cnt++;
    cpu_write(MIRA, 8'h22);
    tick();
    total_cnt++;
    if ({vram_we, vram_waddr} !== {1'b1, 11'd1000})
      $display("FAIL empty_mirror got we%b a%0d want 1 1000",
               vram_we, vram_waddr);
    else pass_cnt++;
    cpu_cs = 0; cpu_we = 0;
  endtask

  task automatic test_halt_abort();
    bit seen = 0;
    phi2 = 1;
    repeat (4) tick();
    halt_req = 1;
    tick();
    total_cnt++;
    if (rdy !== 0)
      $display("FAIL abort_wait got rdy%b want 0", rdy);
    else pass_cnt++;
    halt_req = 0;
    tick();
    seen = seen | halted;
    phi2 = 0;
    repeat (SS + 3) begin
      tick();
      seen = seen | halted;
    end
    total_cnt++;
    if (rdy !== 1 || seen !== 0)
      $display("FAIL abort_run got rdy%b halted_seen%b want 1 0", rdy, seen);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int a, d, cfg, o, k;
    bit h, w, cs;
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(15);
      a = $urandom_range(16'hFF00);
      win_write(k, a, a + $urandom_range(2500));
    end
    for (int it = 0; it < 300; it++) begin
      cfg = $urandom_range(15);
      cfg_sel = CW'(cfg);
      k = $urandom_range(9);
      if (k == 0) a = MIRA;
      else if (k < 6) a = (m_start[cfg] + $urandom_range(2600) - 50) & 16'hFFFF;
      else a = $urandom_range(16'hFFFF);
      d = $urandom_range(255);
      cs = $urandom_range(1); w = $urandom_range(1);
      cpu_addr = AW'(a); cpu_din = DW'(d); cpu_cs = cs; cpu_we = w;
      o = exp_ofs(a, cfg, h);
      #1;
      total_cnt++;
      if (vram_size !== VW'(m_end[cfg] - m_start[cfg])) begin
        $display("FAIL rnd_size it%0d got %0d want %0d", it, vram_size,
                 (m_end[cfg] - m_start[cfg]) & 11'h7FF);
        bad++;
      end else pass_cnt++;
      if ($urandom_range(4) == 0) begin
        k = $urandom_range(15);
        win_wr = 1; win_idx = CW'(k);
        win_start = AW'($urandom_range(16'hFF00));
        win_end = AW'(int'(win_start) + $urandom_range(2500) - 200);
      end
      tick();
      if (win_wr) begin
        m_start[win_idx] = win_start;
        m_end[win_idx] = win_end;
        win_wr = 0;
      end
      total_cnt++;
      if (vram_we !== (h & cs & w) ||
          (h & cs & w) && (vram_waddr !== VW'(o) || vram_wdata !== DW'(d))) begin
        $display("FAIL rnd_vram it%0d a%h got we%b a%0d d%h want we%b a%0d d%h",
                 it, a, vram_we, vram_waddr, vram_wdata, h & cs & w, o, d);
        bad++;
      end else pass_cnt++;
      if (bad > 10) break;
    end
    cpu_cs = 0; cpu_we = 0;
  endtask

  task automatic test_mid_reset();
    win_write(5, 16'h1000, 16'h2000);
    cfg_sel = 5;
    cpu_write(16'h1004, 8'h99);
    rst = 1;
    tick();
    rst = 0;
    cpu_cs = 0; cpu_we = 0;
    #1;
    total_cnt++;
    if ({vram_we, rdy, halted} !== 3'b000 || vram_size !== 0)
      $display("FAIL mid_reset got we%b rdy%b h%b size%0d want 0 0 0 0",
               vram_we, rdy, halted, vram_size);
    else pass_cnt++;
    flash_addr = 16'h0ABC; flash_cs = 1;
    #1;
    total_cnt++;
    if (ram_addr !== 16'h0ABC)
      $display("FAIL mid_reset_load got a%h want 0abc", ram_addr);
    else pass_cnt++;
    flash_cs = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_halt();
    test_halted_diag();
    test_window();
    test_mirror_empty();
    test_halt_abort();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
